// File: rtl/onn_pkg.sv
// Shared sizes, run-state encoding and helpers for the ONN run sequencer.
package onn_pkg;

  localparam int unsigned N_NEURON    = 15;
  localparam int unsigned PHASE_W     = 4;
  localparam int unsigned PHASE_VEC_W = N_NEURON * PHASE_W;
  localparam int unsigned PCNT_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_STORE = 3'd4,
    ST_DONE  = 3'd5
  } run_state_e;

  typedef logic [PHASE_VEC_W-1:0] phase_vec_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] v);
    return (v == {PCNT_W{1'b1}}) ? v : v + PCNT_W'(1);
  endfunction

endpackage

// File: rtl/onn_period_timer.sv
// Modulo-OSC_PERIOD oscillation timer; strobes describe the count for the next cycle.
module onn_period_timer #(
  parameter int unsigned OSC_PERIOD = 16,
  localparam int unsigned CNT_W = (OSC_PERIOD > 1) ? $clog2(OSC_PERIOD) : 1
) (
  input  logic sclk,
  input  logic re_n,
  input  logic clr,
  input  logic adv,
  output logic drop_stb_c,
  output logic check_stb_c
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // Restart at zero on clear, otherwise wrap after OSC_PERIOD-1.
  always_comb begin
    count_nxt = '0;
    if (!clr && (count != CNT_W'(OSC_PERIOD - 1))) begin
      count_nxt = count + CNT_W'(1);
    end
  end

  assign drop_stb_c  = (count_nxt == '0);
  assign check_stb_c = (count_nxt == CNT_W'(OSC_PERIOD - 1));

  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      count <= '0;
    end else if (adv) begin
      count <= count_nxt;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/onn_run_sequencer.sv
// Run controller for the 3x5 ONN array: load, periodic drop/check strobes,
// convergence/timeout detection and capture of the settled phase vector.
module onn_run_sequencer
  import onn_pkg::*;
#(
  parameter int unsigned OSC_PERIOD     = 16,
  parameter int unsigned LOAD_CYC       = 2,
  parameter int unsigned STABLE_PERIODS = 3,
  parameter int unsigned MAX_PERIODS    = 255
) (
  input  logic                   sclk,
  input  logic                   re_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_VEC_W-1:0] pattern_in,
  output logic [PHASE_VEC_W-1:0] ini_phase,
  output logic                   neuron_load,
  output logic                   drop,
  output logic                   state_cheak,
  input  logic [N_NEURON-1:0]    state_changed,
  input  logic [PHASE_VEC_W-1:0] phi_in,
  output logic [PHASE_VEC_W-1:0] result_phase,
  output logic                   busy,
  output logic                   done,
  output logic                   converged,
  output logic                   timeout,
  output logic [PCNT_W-1:0]      period_count
);

  localparam int unsigned LCNT_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  run_state_e          state;
  run_state_e          state_nxt;

  logic [LCNT_W-1:0]   load_cnt;
  logic [LCNT_W-1:0]   load_cnt_d;
  logic                any_chg;
  logic                any_chg_d;
  logic [PCNT_W-1:0]   stable_cnt;
  logic [PCNT_W-1:0]   stable_d;
  logic [PCNT_W-1:0]   pcount_d;
  logic                conv_d;
  logic                tmo_d;
  phase_vec_t          ini_d;
  phase_vec_t          res_d;

  logic                load_d;
  logic                drop_d;
  logic                check_d;
  logic                busy_d;
  logic                done_d;

  logic                timer_clr_c;
  logic                timer_adv_c;
  logic                drop_stb_c;
  logic                check_stb_c;

  assign timer_clr_c = (state != ST_RUN);
  assign timer_adv_c = (state_nxt == ST_RUN);

  onn_period_timer #(
    .OSC_PERIOD (OSC_PERIOD)
  ) u_period_timer (
    .sclk        (sclk),
    .re_n        (re_n),
    .clr         (timer_clr_c),
    .adv         (timer_adv_c),
    .drop_stb_c  (drop_stb_c),
    .check_stb_c (check_stb_c)
  );

  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and datapath updates; abort overrides every other transition.
  always_comb begin
    state_nxt  = state;
    load_cnt_d = load_cnt;
    any_chg_d  = any_chg;
    stable_d   = stable_cnt;
    pcount_d   = period_count;
    conv_d     = converged;
    tmo_d      = timeout;
    ini_d      = ini_phase;
    res_d      = result_phase;

    if (abort) begin
      state_nxt = ST_IDLE;
      conv_d    = 1'b0;
      tmo_d     = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nxt  = ST_LOAD;
            ini_d      = pattern_in;
            conv_d     = 1'b0;
            tmo_d      = 1'b0;
            pcount_d   = '0;
            stable_d   = '0;
            load_cnt_d = '0;
          end
        end
        ST_LOAD: begin
          if (load_cnt == LCNT_W'(LOAD_CYC - 1)) begin
            state_nxt = ST_RUN;
          end else begin
            load_cnt_d = load_cnt + LCNT_W'(1);
          end
        end
        ST_RUN: begin
          // The registered state_cheak marks the last timer slot of the period.
          if (state_cheak) begin
            any_chg_d = |state_changed;
            state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          pcount_d = sat_inc(period_count);
          stable_d = any_chg ? '0 : sat_inc(stable_cnt);
          if (stable_d >= PCNT_W'(STABLE_PERIODS)) begin
            state_nxt = ST_STORE;
            conv_d    = 1'b1;
          end else if (pcount_d >= PCNT_W'(MAX_PERIODS)) begin
            state_nxt = ST_STORE;
            tmo_d     = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_STORE: begin
          res_d     = phi_in;
          state_nxt = ST_DONE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Strobe and status values for the coming cycle, registered below.
  always_comb begin
    load_d  = (state_nxt == ST_LOAD);
    drop_d  = (state_nxt == ST_LOAD) || ((state_nxt == ST_RUN) && drop_stb_c);
    check_d = (state_nxt == ST_RUN) && check_stb_c;
    busy_d  = (state_nxt == ST_LOAD) || (state_nxt == ST_RUN) ||
              (state_nxt == ST_CHECK) || (state_nxt == ST_STORE);
    done_d  = (state_nxt == ST_DONE);
  end

  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      load_cnt     <= '0;
      any_chg      <= 1'b0;
      stable_cnt   <= '0;
      period_count <= '0;
      converged    <= 1'b0;
      timeout      <= 1'b0;
      ini_phase    <= '0;
      result_phase <= '0;
      neuron_load  <= 1'b0;
      drop         <= 1'b0;
      state_cheak  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      load_cnt     <= load_cnt_d;
      any_chg      <= any_chg_d;
      stable_cnt   <= stable_d;
      period_count <= pcount_d;
      converged    <= conv_d;
      timeout      <= tmo_d;
      ini_phase    <= ini_d;
      result_phase <= res_d;
      neuron_load  <= load_d;
      drop         <= drop_d;
      state_cheak  <= check_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_onn_run_sequencer.sv
// Self-checking bench for onn_run_sequencer: timeline model per instance plus directed literal checks.
module tb_onn_run_sequencer;
  import onn_pkg::*;

  localparam int P  = 16;
  localparam int L  = 2;
  localparam int NI = 3;

  typedef struct packed {
    logic       load;
    logic       drop;
    logic       chk;
    logic       busy;
    logic       done;
    logic       conv;
    logic       tmo;
    logic [7:0] pc;
  } exp_t;

  logic sclk = 1'b0;
  logic re_n = 1'b0;
  logic [NI-1:0] start = '0;
  logic [NI-1:0] abort = '0;
  logic [PHASE_VEC_W-1:0] pattern_in = '0;
  logic [PHASE_VEC_W-1:0] phi_in = '0;
  logic [N_NEURON-1:0] sc [NI];

  logic [NI-1:0] nload, drp, schk, busy, done, conv, tmo;
  logic [PHASE_VEC_W-1:0] ini [NI];
  logic [PHASE_VEC_W-1:0] res [NI];
  logic [7:0] pc [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model state (per instance)
  bit                     act [NI];
  bit                     abrt [NI];
  int                     t0 [NI];
  int                     n_end [NI];
  int                     store_k [NI];
  bit                     conv_e [NI];
  logic [PHASE_VEC_W-1:0] pat_m [NI];
  logic [PHASE_VEC_W-1:0] res_m [NI];
  logic [7:0]             hold_pc [NI];
  logic [255:0]           plan [NI];
  logic [N_NEURON-1:0]    chg_val [NI];

  always #5 sclk = ~sclk;

  onn_run_sequencer #(.OSC_PERIOD(16), .LOAD_CYC(2), .STABLE_PERIODS(3), .MAX_PERIODS(255)) u_dut0 (
    .sclk(sclk), .re_n(re_n), .start(start[0]), .abort(abort[0]), .pattern_in(pattern_in),
    .ini_phase(ini[0]), .neuron_load(nload[0]), .drop(drp[0]), .state_cheak(schk[0]),
    .state_changed(sc[0]), .phi_in(phi_in), .result_phase(res[0]), .busy(busy[0]),
    .done(done[0]), .converged(conv[0]), .timeout(tmo[0]), .period_count(pc[0]));

  onn_run_sequencer #(.OSC_PERIOD(16), .LOAD_CYC(2), .STABLE_PERIODS(3), .MAX_PERIODS(5)) u_dut1 (
    .sclk(sclk), .re_n(re_n), .start(start[1]), .abort(abort[1]), .pattern_in(pattern_in),
    .ini_phase(ini[1]), .neuron_load(nload[1]), .drop(drp[1]), .state_cheak(schk[1]),
    .state_changed(sc[1]), .phi_in(phi_in), .result_phase(res[1]), .busy(busy[1]),
    .done(done[1]), .converged(conv[1]), .timeout(tmo[1]), .period_count(pc[1]));

  onn_run_sequencer #(.OSC_PERIOD(16), .LOAD_CYC(2), .STABLE_PERIODS(1), .MAX_PERIODS(5)) u_dut2 (
    .sclk(sclk), .re_n(re_n), .start(start[2]), .abort(abort[2]), .pattern_in(pattern_in),
    .ini_phase(ini[2]), .neuron_load(nload[2]), .drop(drp[2]), .state_cheak(schk[2]),
    .state_changed(sc[2]), .phi_in(phi_in), .result_phase(res[2]), .busy(busy[2]),
    .done(done[2]), .converged(conv[2]), .timeout(tmo[2]), .period_count(pc[2]));

  function automatic int maxp(input int i);
    return (i == 0) ? 255 : 5;
  endfunction

  function automatic int stab(input int i);
    return (i == 2) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int inst, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%h expected=%h", name, inst, cyc, a, e);
    end
  endtask

  // Scan the change plan to find how many checks the run lasts and how it ends.
  function automatic void compute_end(input int i);
    int streak;
    streak = 0;
    n_end[i] = 255;
    conv_e[i] = 1'b0;
    for (int p = 1; p < 256; p++) begin
      if (plan[i][p]) streak = 0;
      else streak++;
      if (streak >= stab(i)) begin
        conv_e[i] = 1'b1; n_end[i] = p; break;
      end
      if (p >= maxp(i)) begin
        conv_e[i] = 1'b0; n_end[i] = p; break;
      end
    end
    store_k[i] = L + n_end[i] * (P + 1) + 1;
  endfunction

  // Expected outputs during cycle k (k=1 is the cycle after the accepted start edge).
  function automatic exp_t expect_at(input int i, input int k);
    exp_t e;
    int j, p;
    e = '0;
    if (!act[i] || abrt[i]) begin
      e.pc = hold_pc[i];
      return e;
    end
    if (k <= L) begin
      e.load = 1'b1; e.drop = 1'b1; e.busy = 1'b1;
    end else if (k < store_k[i]) begin
      j = (k - L - 1) % (P + 1);
      p = (k - L - 1) / (P + 1);
      e.drop = (j == 0);
      e.chk  = (j == P - 1);
      e.busy = 1'b1;
      e.pc   = 8'(p);
    end else begin
      e.busy = (k == store_k[i]);
      e.done = (k > store_k[i]);
      e.pc   = 8'(n_end[i]);
      e.conv = conv_e[i];
      e.tmo  = !conv_e[i];
    end
    return e;
  endfunction

  // Model advance on each active edge.
  always @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      for (int i = 0; i < NI; i++) begin
        act[i] = 1'b0; abrt[i] = 1'b0; hold_pc[i] = '0; pat_m[i] = '0; res_m[i] = '0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        int kk;
        bit live, busy_prev;
        kk = cyc - t0[i];
        live = act[i] && !abrt[i];
        busy_prev = live && (kk <= store_k[i]);
        if (live) begin
          if (abort[i]) begin
            hold_pc[i] = expect_at(i, kk).pc;
            abrt[i] = 1'b1;
          end else if (kk == store_k[i]) begin
            res_m[i] = phi_in;
          end
        end
        if (start[i] && !abort[i] && !busy_prev) begin
          act[i] = 1'b1; abrt[i] = 1'b0; t0[i] = cyc; pat_m[i] = pattern_in;
          compute_end(i);
        end
      end
    end
  end

  // Compare every cycle and drive state_changed / phi_in for the cycle ahead.
  always @(negedge sclk) begin
    phi_in = PHASE_VEC_W'({$urandom(), $urandom()});
    for (int i = 0; i < NI; i++) begin
      exp_t e, a;
      int k, j, p;
      k = cyc - t0[i] + 1;
      e = expect_at(i, k);
      a.load = nload[i]; a.drop = drp[i]; a.chk = schk[i]; a.busy = busy[i];
      a.done = done[i]; a.conv = conv[i]; a.tmo = tmo[i]; a.pc = pc[i];
      chk("ctrl", i, 64'(a), 64'(e));
      chk("ini_phase", i, 64'(ini[i]), 64'(pat_m[i]));
      chk("result_phase", i, 64'(res[i]), 64'(res_m[i]));
      sc[i] = N_NEURON'($urandom());
      if (act[i] && !abrt[i] && k > L && k < store_k[i]) begin
        j = (k - L - 1) % (P + 1);
        p = (k - L - 1) / (P + 1);
        if (j == P - 1) sc[i] = plan[i][p + 1] ? chg_val[i] : '0;
      end
    end
  end

  task automatic wait_k(input int s, input int k);
    int target, guard;
    target = s + k - 1;
    guard = 0;
    while (cyc != target) begin
      @(negedge sclk);
      guard++;
      if (guard > 3000) begin
        n_checks++; n_fail++;
        $display("FAIL wait_k target=%0d cyc=%0d", target, cyc);
        break;
      end
    end
  endtask

  task automatic start_run(input int i, input logic [PHASE_VEC_W-1:0] pat, output int s);
    @(negedge sclk);
    pattern_in = pat;
    start[i] = 1'b1;
    s = cyc + 1;
    @(negedge sclk);
    start[i] = 1'b0;
    pattern_in = PHASE_VEC_W'({$urandom(), $urandom()});
  endtask

  initial begin
    int s;
    logic [PHASE_VEC_W-1:0] phi54;
    for (int i = 0; i < NI; i++) begin
      plan[i] = '0; chg_val[i] = '0; sc[i] = '0; t0[i] = 0; n_end[i] = 0; store_k[i] = 0;
    end
    chg_val[0] = 15'h0080;
    chg_val[1] = 15'h0001;
    chg_val[2] = 15'h0001;

    // Reset held
    repeat (3) @(negedge sclk);
    #1;
    chk("rst_busy", 0, 64'(busy[0]), 64'(0));
    chk("rst_pc", 0, 64'(pc[0]), 64'(0));
    chk("rst_ini", 0, 64'(ini[0]), 64'(0));
    re_n = 1'b1;
    repeat (2) @(negedge sclk);

    // Quiet convergence
    start_run(0, 60'h123456789ABCDEF, s);
    wait_k(s, 1);  #1; chk("t2_load1", 0, 64'(nload[0]), 64'(1));
    wait_k(s, 3);  #1; chk("t2_drop3", 0, 64'(drp[0]), 64'(1));
    chk("t2_load3", 0, 64'(nload[0]), 64'(0));
    wait_k(s, 18); #1; chk("t2_chk18", 0, 64'(schk[0]), 64'(1));
    wait_k(s, 54); #1; phi54 = phi_in; chk("t2_busy54", 0, 64'(busy[0]), 64'(1));
    wait_k(s, 55); #1;
    chk("t2_done", 0, 64'(done[0]), 64'(1));
    chk("t2_conv", 0, 64'(conv[0]), 64'(1));
    chk("t2_pc", 0, 64'(pc[0]), 64'(3));
    chk("t2_res", 0, 64'(res[0]), 64'(phi54));
    repeat (3) @(negedge sclk);

    // Restart from DONE with late settle: changes on checks 1..4
    plan[0] = '0;
    for (int p = 1; p <= 4; p++) plan[0][p] = 1'b1;
    start_run(0, 60'hFEDCBA987654321, s);
    wait_k(s, 1); #1;
    chk("t6_ini", 0, 64'(ini[0]), 64'h0FEDCBA987654321);
    chk("t6_conv_clr", 0, 64'(conv[0]), 64'(0));
    chk("t6_pc_clr", 0, 64'(pc[0]), 64'(0));
    wait_k(s, 3);  #1; chk("t6_drop3", 0, 64'(drp[0]), 64'(1));
    wait_k(s, 18); #1; chk("t6_chk18", 0, 64'(schk[0]), 64'(1));
    wait_k(s, 123); #1;
    chk("t3_done", 0, 64'(done[0]), 64'(1));
    chk("t3_conv", 0, 64'(conv[0]), 64'(1));
    chk("t3_pc", 0, 64'(pc[0]), 64'(7));
    repeat (2) @(negedge sclk);

    // Start while busy is ignored; abort on a would-converge CHECK
    plan[0] = '0;
    start_run(0, 60'h0A5A5A5A5A5A5A5, s);
    wait_k(s, 10);
    pattern_in = 60'h111111111111111;
    start[0] = 1'b1;
    @(negedge sclk);
    start[0] = 1'b0;
    wait_k(s, 12); #1; chk("t5_ini_kept", 0, 64'(ini[0]), 64'h00A5A5A5A5A5A5A5);
    chk("t5_busy", 0, 64'(busy[0]), 64'(1));
    wait_k(s, 53);
    abort[0] = 1'b1;
    @(negedge sclk);
    abort[0] = 1'b0;
    wait_k(s, 56); #1;
    chk("t5_done", 0, 64'(done[0]), 64'(0));
    chk("t5_conv", 0, 64'(conv[0]), 64'(0));
    chk("t5_busy_off", 0, 64'(busy[0]), 64'(0));
    chk("t5_pc_kept", 0, 64'(pc[0]), 64'(2));

    // Timeout: changes on every check
    plan[1] = '1;
    start_run(1, 60'h0C3C3C3C3C3C3C3, s);
    wait_k(s, 89); #1;
    chk("t4_done", 1, 64'(done[1]), 64'(1));
    chk("t4_tmo", 1, 64'(tmo[1]), 64'(1));
    chk("t4_conv", 1, 64'(conv[1]), 64'(0));
    chk("t4_pc", 1, 64'(pc[1]), 64'(5));

    // Convergence on the final allowed check wins
    plan[2] = '0;
    for (int p = 1; p <= 4; p++) plan[2][p] = 1'b1;
    start_run(2, 60'h0777777777777777, s);
    wait_k(s, 89); #1;
    chk("t4v_conv", 2, 64'(conv[2]), 64'(1));
    chk("t4v_tmo", 2, 64'(tmo[2]), 64'(0));
    chk("t4v_pc", 2, 64'(pc[2]), 64'(5));

    // Asynchronous reset during a state_cheak cycle
    plan[0] = '0;
    start_run(0, 60'h0246802468024680, s);
    wait_k(s, 18); #2;
    chk("ar_chk_pre", 0, 64'(schk[0]), 64'(1));
    re_n = 1'b0;
    #1;
    chk("ar_chk", 0, 64'(schk[0]), 64'(0));
    chk("ar_busy", 0, 64'(busy[0]), 64'(0));
    chk("ar_ini", 0, 64'(ini[0]), 64'(0));
    repeat (2) @(negedge sclk);
    re_n = 1'b1;
    repeat (2) @(negedge sclk);

    // Asynchronous reset during a drop cycle
    start_run(0, 60'h0135791357913579, s);
    wait_k(s, 3); #2;
    chk("ar_drop_pre", 0, 64'(drp[0]), 64'(1));
    re_n = 1'b0;
    #1;
    chk("ar_drop", 0, 64'(drp[0]), 64'(0));
    chk("ar_busy2", 0, 64'(busy[0]), 64'(0));
    repeat (2) @(negedge sclk);
    re_n = 1'b1;
    repeat (5) @(negedge sclk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
